seq_mult_signed: RTL and testbench
==================================

// Module: seq_mult_signed
// PURPOSE
//  Parametrised iterative multiplier for the CPU datapath. It processes one multiplier bit per clock
//  and supports both signed (two's complement) and unsigned operands. It replaces the combinational
//  16-bit array multiplier when area matters more than latency. For signed operands, the final
//  partial product is subtracted rather than added. Sits beside the ALU, driven by a start/done handshake.
// PARAMETERS
//  WIDTH  16  operand width in bits (>=4); product is 2*WIDTH bits
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  start        in   1        request; sampled only while idle (busy=0)
//  signed_mode  in   1        1: a,b two's complement; 0: unsigned; sampled with start
//  a            in   WIDTH    multiplicand; sampled with start
//  b            in   WIDTH    multiplier; sampled with start
//  busy         out  1        operation in progress
//  done         out  1        one-cycle pulse: product valid and updated this cycle
//  product      out  2*WIDTH  result; held stable until the next accepted start completes
// BEHAVIOUR
//  Reset: rst=1 asynchronously forces state=IDLE, busy=0, done=0, product=0, internal acc/count=0.
//  States: IDLE -> RUN on start=1 at an edge. RUN -> IDLE after WIDTH iterations.
//  Latency: start sampled at edge E0. busy=1 from E0 through E0+WIDTH-1 (WIDTH iterations).
//    At edge E0+WIDTH: product is loaded, done=1 for exactly one cycle, busy=0.
//    Next start is accepted at E0+WIDTH+1 at the earliest (throughput WIDTH+1 cycles).
//  start while busy=1 is ignored: no queueing, and the operands of the running op are unaffected.
//  a, b and signed_mode are latched at E0. Later input changes have no effect on the running op.
//  Datapath:
//    Accumulator acc is WIDTH+1 bits, initialised to 0.
//    Multiplier shift register mq is WIDTH bits, loaded with b.
//    Multiplicand ext is WIDTH+1 bits: sign-extended a if signed_mode, otherwise zero-extended.
//  Iteration i (0..WIDTH-1):
//    pp = mq[0] ? ext : 0.
//    sum = acc + pp, except at i==WIDTH-1 with signed_mode=1, where sum = acc - pp
//      (weight of b's sign bit is negative).
//    {acc, mq} <= {sum[WIDTH] (signed) or carry-out (unsigned), sum, mq[WIDTH-1:1]} shifted right by one.
//    Unsigned mode shifts in the carry; signed mode shifts in sum's sign bit (arithmetic shift).
//  Result: product = {acc[WIDTH-1:0], mq} after the final iteration. No overflow is possible;
//    full 2*WIDTH bits are exact for both modes.
//  Counter: ceil(log2(WIDTH)) bits, counts 0..WIDTH-1, cleared on entry to RUN.
//  Boundaries:
//    b=0 -> product 0.
//    a=most-negative, b=most-negative (signed) -> +2^(2*WIDTH-2), no wrap.
//    rst mid-RUN -> aborts immediately, done never pulses, product=0.
//    start at the same edge on which RUN finishes -> ignored (busy still 1 at that edge).
// STRUCTURE
//  Shared package mult_pkg: state encoding constants (ST_IDLE, ST_RUN), and a function computing
//    the counter width from WIDTH.
//  One sub-module, mult_row_addsub: combinational (WIDTH+1)-bit add/subtract of the gated
//    partial product with carry/sign-out. It is the parametrised generalisation of the array-row cell.
//  Top holds the FSM, counter, acc/mq registers and output registers.
// TESTING
//  1 WIDTH=16, unsigned, a=16'hFFFF b=16'hFFFF -> done exactly 16 cycles after start edge, product=32'hFFFE0001.
//  2 WIDTH=16, signed, a=16'h8000 b=16'h8000 -> product=32'h40000000; a=16'hFFFF b=16'h0001 -> 32'hFFFFFFFF.
//  3 WIDTH=8, signed, a=8'h80 b=8'h7F -> product=16'hC080 (-16256); unsigned same operands -> 16'h3F80.
//  4 start pulsed with new operands every cycle during RUN -> ignored; first result unchanged, single done pulse.
//  5 rst asserted mid-RUN (iteration 7) -> busy=0, done=0, product=0 same cycle. Fresh start then completes correctly.
//  6 back-to-back: start held high -> ops accepted every WIDTH+1 cycles. Product holds between done pulses.
//    Random 10k signed/unsigned vectors match a behavioural model.

Source files
------------

// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the iterative multiplier:
//   state_t    - FSM state encoding (ST_IDLE, ST_RUN)
//   cnt_width  - width of the iteration counter for a given operand width
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter holds 0..width-1, so ceil(log2(width)) bits suffice.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/mult_row_addsub.sv
// -----------------------------------------------------------------------------
// mult_row_addsub
// One row of the multiplier: gates the multiplicand with the current
// multiplier bit, then adds it to (or subtracts it from) the accumulator.
// Ports:
//   acc          in   WIDTH+1  running partial sum
//   mcand        in   WIDTH+1  extended multiplicand
//   sel          in   1        current multiplier bit (gates mcand)
//   sub          in   1        1: acc - pp, 0: acc + pp
//   signed_mode  in   1        selects which bit is shifted into acc's MSB
//   sum          out  WIDTH+1  acc +/- pp
//   fill         out  1        sign of sum (signed) or carry-out (unsigned)
// -----------------------------------------------------------------------------
module mult_row_addsub #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] mcand,
    input  logic           sel,
    input  logic           sub,
    input  logic           signed_mode,
    output logic [WIDTH:0] sum,
    output logic           fill
);

    logic [WIDTH:0]   pp;
    logic [WIDTH:0]   opnd;
    logic [WIDTH+1:0] total;

    always_comb begin
        pp    = sel ? mcand : '0;
        // Two's complement subtraction: invert and add one via the carry-in.
        opnd  = sub ? ~pp : pp;
        total = {1'b0, acc} + {1'b0, opnd} + {{(WIDTH + 1){1'b0}}, sub};
        sum   = total[WIDTH:0];
        fill  = signed_mode ? total[WIDTH] : total[WIDTH+1];
    end

endmodule

// File: rtl/seq_mult_signed.sv
// -----------------------------------------------------------------------------
// seq_mult_signed
// Iterative shift-add multiplier, one multiplier bit per clock, for signed
// (two's complement) or unsigned operands. In signed mode the last partial
// product is subtracted because b's sign bit carries negative weight.
// Ports:
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous, active-high reset
//   start        in   1        request; sampled only while idle
//   signed_mode  in   1        1: signed operands; sampled with start
//   a            in   WIDTH    multiplicand; sampled with start
//   b            in   WIDTH    multiplier; sampled with start
//   busy         out  1        operation in progress
//   done         out  1        one-cycle pulse when product is updated
//   product      out  2*WIDTH  result, held until the next op completes
// -----------------------------------------------------------------------------
module seq_mult_signed
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   count;
    logic [WIDTH:0]  acc;
    logic [WIDTH:0]  ext;
    logic [WIDTH-1:0] mq;
    logic            sm_q;

    logic            accept;
    logic            last;
    logic [WIDTH:0]  sum;
    logic            fill;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (count == LAST);

    mult_row_addsub #(.WIDTH(WIDTH)) u_row (
        .acc         (acc),
        .mcand       (ext),
        .sel         (mq[0]),
        .sub         (sm_q & last),
        .signed_mode (sm_q),
        .sum         (sum),
        .fill        (fill)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so every path drives state_nx and no latch is inferred.
        state_nx = state;
        case (state)
            ST_IDLE: if (start) state_nx = ST_RUN;
            ST_RUN:  if (last)  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Output logic.
    always_comb begin
        busy = (state == ST_RUN);
    end

    // Datapath: operand latch, accumulator/multiplier shift register, counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too; an aborted op must leave no stale partial sum.
            acc   <= '0;
            mq    <= '0;
            ext   <= '0;
            sm_q  <= 1'b0;
            count <= '0;
        end else if (accept) begin
            acc   <= '0;
            mq    <= b;
            ext   <= signed_mode ? {a[WIDTH-1], a} : {1'b0, a};
            sm_q  <= signed_mode;
            count <= '0;
        end else if (state == ST_RUN) begin
            // NOTE: non-blocking so acc and mq both shift from their pre-edge values.
            {acc, mq} <= {fill, sum, mq[WIDTH-1:1]};
            count     <= count + CW'(1);
        end
    end

    // Result register: loaded from the final shifted value on the last iteration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (state == ST_RUN && last) begin
                done    <= 1'b1;
                product <= {sum, mq[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_seq_mult_signed.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_signed
// Drives a 16-bit and an 8-bit instance. A cycle-level behavioural model
// (operation timer plus plain integer multiplication) predicts busy, done and
// product; a compare process checks both instances on every falling edge.
// -----------------------------------------------------------------------------
module tb_seq_mult_signed;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [2];
    logic        sm_s    [2];
    logic [15:0] a_s     [2];
    logic [15:0] b_s     [2];

    logic        busy16, done16, busy8, done8;
    logic [31:0] p16;
    logic [15:0] p8;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    seq_mult_signed #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start_s[0]), .signed_mode(sm_s[0]),
        .a(a_s[0]), .b(b_s[0]), .busy(busy16), .done(done16), .product(p16)
    );

    seq_mult_signed #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start_s[1]), .signed_mode(sm_s[1]),
        .a(a_s[1][7:0]), .b(b_s[1][7:0]), .busy(busy8), .done(done8), .product(p8)
    );

    function automatic int w_of(input int k);
        return (k == 0) ? 16 : 8;
    endfunction

    function automatic logic busy_of(input int k);
        return (k == 0) ? busy16 : busy8;
    endfunction

    function automatic logic done_of(input int k);
        return (k == 0) ? done16 : done8;
    endfunction

    function automatic logic [31:0] prod_of(input int k);
        return (k == 0) ? p16 : {16'h0000, p8};
    endfunction

    // Exact product of w-bit operands, truncated to 2*w bits.
    function automatic logic [31:0] ref_mul(input int w, input logic sm,
                                            input logic [15:0] a, input logic [15:0] b);
        longint sa, sb, mask, r;
        mask = (longint'(1) << w) - 1;
        sa   = longint'(a) & mask;
        sb   = longint'(b) & mask;
        if (sm) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        r = (sa * sb) & ((longint'(1) << (2 * w)) - 1);
        return r[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_busy [2];
    bit          m_done [2];
    logic [31:0] m_prod [2];
    logic [31:0] m_pend [2];
    int          m_left [2];

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0;
                m_done[k] = 1'b0;
                m_prod[k] = '0;
                m_left[k] = 0;
            end else begin
                m_done[k] = 1'b0;
                if (m_busy[k]) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                        m_prod[k] = m_pend[k];
                    end
                end else if (start_s[k]) begin
                    m_busy[k] = 1'b1;
                    m_left[k] = w_of(k);
                    m_pend[k] = ref_mul(w_of(k), sm_s[k], a_s[k], b_s[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cmp%0d_busy", w_of(k)), 64'(busy_of(k)), 64'(m_busy[k]));
                check($sformatf("cmp%0d_done", w_of(k)), 64'(done_of(k)), 64'(m_done[k]));
                check($sformatf("cmp%0d_prod", w_of(k)), 64'(prod_of(k)), 64'(m_prod[k]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_idle(input int k);
        int n = 0;
        while (busy_of(k) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Issue one op, scramble inputs after acceptance, measure latency and result.
    task automatic do_op(input int k, input logic sm, input logic [15:0] a,
                         input logic [15:0] b, input logic [31:0] exp, input string name);
        int n = 0;
        wait_idle(k);
        start_s[k] = 1'b1; sm_s[k] = sm; a_s[k] = a; b_s[k] = b;
        @(posedge clk); #1;
        start_s[k] = 1'b0; sm_s[k] = ~sm; a_s[k] = 16'($urandom); b_s[k] = 16'($urandom);
        while (!done_of(k) && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, 64'(n), 64'(w_of(k)));
        check({name, "_product"}, 64'(prod_of(k)), 64'(exp));
    endtask

    function automatic logic [15:0] pick(input int w);
        logic [15:0] v;
        logic [15:0] mask;
        mask = 16'((32'd1 << w) - 1);
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = 16'd1;
            2:       v = mask;
            3:       v = 16'(32'd1 << (w - 1));
            4:       v = 16'((32'd1 << (w - 1)) - 1);
            default: v = 16'($urandom);
        endcase
        return v & mask;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int pulses;
        int n_done;
        int d_at [3];

        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start_s[k] = 1'b0; sm_s[k] = 1'b0; a_s[k] = '0; b_s[k] = '0;
        end
        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy16", 64'(busy16), 64'd0);
        check("reset_done16", 64'(done16), 64'd0);
        check("reset_prod16", 64'(p16), 64'd0);
        check("reset_prod8",  64'(p8),  64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Pin the model with hand-computed values.
        check("model_u16_ffff", 64'(ref_mul(16, 1'b0, 16'hFFFF, 16'hFFFF)), 64'h0000_0000_FFFE_0001);
        check("model_s16_min",  64'(ref_mul(16, 1'b1, 16'h8000, 16'h8000)), 64'h0000_0000_4000_0000);
        check("model_s8_mixed", 64'(ref_mul(8,  1'b1, 16'h0080, 16'h007F)), 64'h0000_0000_0000_C080);
        check("model_u8_mixed", 64'(ref_mul(8,  1'b0, 16'h0080, 16'h007F)), 64'h0000_0000_0000_3F80);

        @(posedge clk); #1;

        // Directed operand cases.
        do_op(0, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "u16_ffff");
        do_op(0, 1'b1, 16'h8000, 16'h8000, 32'h4000_0000, "s16_minmin");
        do_op(0, 1'b1, 16'hFFFF, 16'h0001, 32'hFFFF_FFFF, "s16_neg1");
        do_op(0, 1'b1, 16'h1234, 16'h0000, 32'h0000_0000, "s16_bzero");
        do_op(1, 1'b1, 16'h0080, 16'h007F, 32'h0000_C080, "s8_mixed");
        do_op(1, 1'b0, 16'h0080, 16'h007F, 32'h0000_3F80, "u8_mixed");
        do_op(1, 1'b1, 16'h0080, 16'h0080, 32'h0000_4000, "s8_minmin");

        // start pulsed every cycle while running, including on the finishing edge.
        wait_idle(0);
        start_s[0] = 1'b1; sm_s[0] = 1'b0; a_s[0] = 16'h1234; b_s[0] = 16'h5678;
        @(posedge clk); #1;
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            start_s[0] = 1'b1; sm_s[0] = 1'($urandom); a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
            @(posedge clk); #1;
            if (done16) pulses++;
        end
        start_s[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            if (done16) pulses++;
        end
        check("ignore_start_pulses", 64'(pulses), 64'd1);
        check("ignore_start_prod", 64'(p16), 64'h0626_0060);
        check("ignore_start_idle", 64'(busy16), 64'd0);

        // Asynchronous reset in the middle of an operation.
        start_s[0] = 1'b1; sm_s[0] = 1'b1; a_s[0] = 16'h7FFF; b_s[0] = 16'h8001;
        @(posedge clk); #1;
        start_s[0] = 1'b0;
        repeat (7) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("abort_busy", 64'(busy16), 64'd0);
        check("abort_done", 64'(done16), 64'd0);
        check("abort_prod", 64'(p16), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done16) pulses++;
        end
        check("abort_no_done", 64'(pulses), 64'd0);
        do_op(0, 1'b1, 16'h8000, 16'h7FFF, 32'hC000_8000, "after_abort");

        // start held high: one op every WIDTH+1 cycles.
        wait_idle(0);
        n_done = 0;
        for (int c = 1; c <= 55; c++) begin
            start_s[0] = 1'b1; sm_s[0] = 1'($urandom); a_s[0] = 16'($urandom); b_s[0] = 16'($urandom);
            @(posedge clk); #1;
            if (done16) begin
                if (n_done < 3) d_at[n_done] = c;
                n_done++;
            end
        end
        start_s[0] = 1'b0;
        check("b2b_count", 64'(n_done), 64'd3);
        if (n_done >= 3) begin
            check("b2b_gap1", 64'(d_at[1] - d_at[0]), 64'd17);
            check("b2b_gap2", 64'(d_at[2] - d_at[1]), 64'd17);
        end
        wait_idle(0);

        // Randomised traffic on both instances; the compare process does the checking.
        for (int cyc = 0; cyc < 40000; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                start_s[k] = ($urandom_range(0, 3) != 0);
                sm_s[k]    = 1'($urandom);
                a_s[k]     = pick(w_of(k));
                b_s[k]     = pick(w_of(k));
            end
            @(posedge clk); #1;
        end
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(posedge clk);
        #1;

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
